// File: rtl/sd_pkg.sv
// Shared constants and state encodings for the SD block-read sequencer and its
// command handshake helper.
package sd_pkg;

  localparam logic [5:0] SD_CMD_RD_SINGLE = 6'd17;
  localparam logic [5:0] SD_CMD_RD_MULTI  = 6'd18;
  localparam logic [5:0] SD_CMD_STOP      = 6'd12;

  localparam int SD_BLOCK_SIZE = 512;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_SEND_RD   = 3'd1,
    ST_DATA      = 3'd2,
    ST_RELEASE   = 3'd3,
    ST_SEND_STOP = 3'd4,
    ST_DONE      = 3'd5
  } state_t;

  typedef enum logic [1:0] {
    CI_IDLE = 2'd0,
    CI_BUSY = 2'd1,
    CI_GAP  = 2'd2
  } cmd_state_t;

endpackage

// File: rtl/sd_cmd_issue.sv
// Command handshake helper: latches a command on request, holds cmd_start and
// the fields until the responder answers, then idles for one cycle.
module sd_cmd_issue
  import sd_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        issue,
  input  logic [5:0]  issue_index,
  input  logic [31:0] issue_arg,
  output logic        cmd_start,
  output logic [5:0]  cmd_index,
  output logic [31:0] cmd_arg,
  input  logic        cmd_done,
  input  logic        cmd_fail,
  output logic        rsp_ok,
  output logic        rsp_fail
);

  cmd_state_t cs;

  assign cmd_start = (cs == CI_BUSY);
  // A simultaneous done and fail is reported as a failure only.
  assign rsp_fail  = (cs == CI_BUSY) && cmd_fail;
  assign rsp_ok    = (cs == CI_BUSY) && cmd_done && !cmd_fail;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      cs        <= CI_IDLE;
      cmd_index <= '0;
      cmd_arg   <= '0;
    end else begin
      case (cs)
        CI_IDLE: begin
          if (issue) begin
            cmd_index <= issue_index;
            cmd_arg   <= issue_arg;
            cs        <= CI_BUSY;
          end
        end
        CI_BUSY: begin
          if (cmd_done || cmd_fail) cs <= CI_GAP;
        end
        // Guarantees cmd_start is low for a cycle before a back-to-back command.
        CI_GAP:  cs <= CI_IDLE;
        default: cs <= CI_IDLE;
      endcase
    end
  end

endmodule

// File: rtl/sd_block_read_sequencer.sv
// Multi-block SD read sequencer: issues CMD17/CMD18, enables the data receiver
// once per block, stops with CMD12 and retries from the failing block on CRC error.
module sd_block_read_sequencer
  import sd_pkg::*;
#(
  parameter int         MAX_RETRY     = 2,
  parameter logic [5:0] CMD_RD_SINGLE = SD_CMD_RD_SINGLE,
  parameter logic [5:0] CMD_RD_MULTI  = SD_CMD_RD_MULTI,
  parameter logic [5:0] CMD_STOP      = SD_CMD_STOP
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rd_req,
  input  logic [31:0] rd_addr,
  input  logic [15:0] rd_count,
  output logic        rd_busy,
  output logic        rd_done,
  output logic        rd_err,
  output logic [15:0] blocks_ok,
  output logic        cmd_start,
  output logic [5:0]  cmd_index,
  output logic [31:0] cmd_arg,
  input  logic        cmd_done,
  input  logic        cmd_fail,
  output logic        get_en,
  input  logic        get_complete,
  input  logic        get_crc_fail,
  output logic [31:0] block_read_count
);

  state_t      state;
  logic [31:0] addr_q;
  logic [15:0] count_q;
  logic [7:0]  retry;
  logic        retry_pend;
  logic        multi_q;

  logic        multi_now;
  logic        issue;
  logic [5:0]  issue_index;
  logic [31:0] issue_arg;
  logic        rsp_ok;
  logic        rsp_fail;

  // A read restarts at the first block not yet received, so the command kind
  // depends on how many blocks remain.
  assign multi_now   = (count_q - blocks_ok) != 16'd1;
  assign issue       = (state == ST_SEND_RD) || (state == ST_SEND_STOP);
  assign issue_index = (state == ST_SEND_STOP) ? CMD_STOP
                     : (multi_now ? CMD_RD_MULTI : CMD_RD_SINGLE);
  assign issue_arg   = (state == ST_SEND_STOP) ? 32'd0 : addr_q + {16'd0, blocks_ok};

  assign get_en           = (state == ST_DATA);
  assign rd_busy          = (state != ST_IDLE) && (state != ST_DONE);
  assign block_read_count = {16'd0, blocks_ok};

  sd_cmd_issue u_cmd (
    .clk         (clk),
    .rst         (rst),
    .issue       (issue),
    .issue_index (issue_index),
    .issue_arg   (issue_arg),
    .cmd_start   (cmd_start),
    .cmd_index   (cmd_index),
    .cmd_arg     (cmd_arg),
    .cmd_done    (cmd_done),
    .cmd_fail    (cmd_fail),
    .rsp_ok      (rsp_ok),
    .rsp_fail    (rsp_fail)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_IDLE;
      addr_q     <= '0;
      count_q    <= '0;
      retry      <= '0;
      retry_pend <= 1'b0;
      multi_q    <= 1'b0;
      blocks_ok  <= '0;
      rd_err     <= 1'b0;
      rd_done    <= 1'b0;
    end else begin
      rd_done <= (state == ST_DONE);
      case (state)
        ST_IDLE: begin
          if (rd_req) begin
            rd_err <= 1'b0;
            if (rd_count == 16'd0) begin
              state <= ST_DONE;
            end else begin
              addr_q     <= rd_addr;
              count_q    <= rd_count;
              blocks_ok  <= '0;
              retry      <= '0;
              retry_pend <= 1'b0;
              state      <= ST_SEND_RD;
            end
          end
        end
        ST_SEND_RD: begin
          if (rsp_fail) begin
            rd_err <= 1'b1;
            state  <= ST_DONE;
          end else if (rsp_ok) begin
            multi_q <= multi_now;
            state   <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (get_complete) begin
            if (get_crc_fail) retry_pend <= 1'b1;
            else              blocks_ok  <= blocks_ok + 16'd1;
            state <= ST_RELEASE;
          end
        end
        ST_RELEASE: begin
          if (!get_complete) begin
            if (retry_pend && retry == 8'(MAX_RETRY)) begin
              rd_err     <= 1'b1;
              retry_pend <= 1'b0;
              state      <= multi_q ? ST_SEND_STOP : ST_DONE;
            end else if (retry_pend) begin
              retry <= retry + 8'd1;
              if (multi_q) begin
                state <= ST_SEND_STOP;
              end else begin
                retry_pend <= 1'b0;
                state      <= ST_SEND_RD;
              end
            end else if (blocks_ok == count_q) begin
              state <= multi_q ? ST_SEND_STOP : ST_DONE;
            end else begin
              state <= ST_DATA;
            end
          end
        end
        ST_SEND_STOP: begin
          if (rsp_fail) begin
            rd_err <= 1'b1;
            state  <= ST_DONE;
          end else if (rsp_ok) begin
            // A still-pending retry means the stop was only there to restart.
            if (retry_pend) begin
              retry_pend <= 1'b0;
              state      <= ST_SEND_RD;
            end else begin
              state <= ST_DONE;
            end
          end
        end
        ST_DONE: state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
